// File: rtl/lc3b_types.sv
// Shared types for the instruction/data cache to physical-memory arbiter.
package lc3b_types;

  localparam int LC3B_LINE_W = 128;

  typedef logic [15:0]            lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_c_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } lc3b_arb_state;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } lc3b_grant;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-client arbiter sharing one physical-memory port between I-cache and D-cache.
// Contended grants alternate; every transaction is followed by one IDLE cycle.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pmem_read,
  input  lc3b_word          i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  lc3b_word          d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output lc3b_word          pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  lc3b_arb_state state_q, state_d;
  lc3b_grant     last_q, last_d;
  logic          i_req, d_req;
  logic          i_done, d_done;

  assign i_req  = i_pmem_read;
  assign d_req  = d_pmem_read | d_pmem_write;
  assign i_done = (state_q == SERVE_I) & pmem_resp;
  assign d_done = (state_q == SERVE_D) & pmem_resp;

  // D wins a tie unless it was the last one served
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && (!i_req || (last_q == GRANT_I))) state_d = SERVE_D;
        else if (i_req)                                state_d = SERVE_I;
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_d = IDLE;
          last_d  = GRANT_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
          last_d  = GRANT_D;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= GRANT_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (state_q)
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
      end
      SERVE_D: begin
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
      end
      default: ;
    endcase
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (i_done),
    .count (i_grant_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (d_done),
    .count (d_grant_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural model checked every cycle plus directed scenarios.
module tb_mem_arbiter;

  localparam int LW = 128;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_pmem_read = 1'b0;
  logic [15:0]   i_pmem_address = '0;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [15:0]   d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  logic [LW-1:0] i_pmem_rdata, d_pmem_rdata, pmem_wdata;
  logic          i_pmem_resp, d_pmem_resp, pmem_read, pmem_write;
  logic [15:0]   pmem_address, i_grant_cnt, d_grant_cnt;

  logic [LW-1:0] s_i_rdata, s_d_rdata, s_wdata;
  logic          s_i_resp, s_d_resp, s_read, s_write;
  logic [15:0]   s_address;
  logic [SW-1:0] s_i_cnt, s_d_cnt;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  // Narrow-counter copy exposes saturation within a few transactions
  mem_arbiter #(.LINE_W(LW), .CNT_W(SW)) u_small (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(s_i_rdata), .i_pmem_resp(s_i_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(s_d_rdata), .d_pmem_resp(s_d_resp),
    .pmem_read(s_read), .pmem_write(s_write),
    .pmem_address(s_address), .pmem_wdata(s_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .i_grant_cnt(s_i_cnt), .d_grant_cnt(s_d_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Model: who is being served (0 none, 1 I, 2 D), who was served last, completions
  int m_srv = 0;
  int m_last = 1;
  int m_icnt = 0;
  int m_dcnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_srv = 0; m_last = 1; m_icnt = 0; m_dcnt = 0;
    end else if (m_srv == 0) begin
      if ((d_pmem_read || d_pmem_write) && (!i_pmem_read || m_last == 1)) m_srv = 2;
      else if (i_pmem_read) m_srv = 1;
    end else if (pmem_resp) begin
      if (m_srv == 1) m_icnt++;
      else m_dcnt++;
      m_last = m_srv;
      m_srv = 0;
    end
  end

  function automatic logic [63:0] sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return 64'((v > top) ? top : v);
  endfunction

  always @(negedge clk) begin
    chk("rd", 64'(pmem_read),
        64'((m_srv == 1) || (m_srv == 2 && d_pmem_read && !d_pmem_write)));
    chk("wr", 64'(pmem_write), 64'(m_srv == 2 && d_pmem_write));
    chk("i_resp", 64'(i_pmem_resp), 64'(m_srv == 1 && pmem_resp));
    chk("d_resp", 64'(d_pmem_resp), 64'(m_srv == 2 && pmem_resp));
    if (m_srv == 1) chk("addr_i", 64'(pmem_address), 64'(i_pmem_address));
    if (m_srv == 2) chk("addr_d", 64'(pmem_address), 64'(d_pmem_address));
    chkw("wdata", pmem_wdata, (m_srv == 2) ? d_pmem_wdata : '0);
    chkw("i_rdata", i_pmem_rdata, pmem_rdata);
    chkw("d_rdata", d_pmem_rdata, pmem_rdata);
    chk("i_cnt", 64'(i_grant_cnt), sat(m_icnt, 16));
    chk("d_cnt", 64'(d_grant_cnt), sat(m_dcnt, 16));
    chk("s_i_cnt", 64'(s_i_cnt), sat(m_icnt, SW));
    chk("s_d_cnt", 64'(s_d_cnt), sat(m_dcnt, SW));
  end

  typedef struct {
    int            kind;
    int            cyc;
    logic [15:0]   addr;
    logic          wr;
    logic [LW-1:0] rdata;
  } txn_t;
  txn_t txq[$];

  always @(negedge clk) begin
    if (i_pmem_resp) txq.push_back('{kind: 0, cyc: cyc, addr: pmem_address, wr: pmem_write, rdata: i_pmem_rdata});
    if (d_pmem_resp) txq.push_back('{kind: 1, cyc: cyc, addr: pmem_address, wr: pmem_write, rdata: d_pmem_rdata});
  end

  // Memory responder: completes after mem_lat strobe cycles
  bit            mem_auto = 1'b0;
  int            mem_lat = 3;
  int            mem_cnt = 0;
  logic [LW-1:0] mem_data = '0;

  always @(posedge clk) begin
    #1;
    if (mem_auto) begin
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        mem_cnt = 0;
      end else if (pmem_read || pmem_write) begin
        mem_cnt++;
        if (mem_cnt == mem_lat) begin
          pmem_resp = 1'b1;
          pmem_rdata = mem_data;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  task automatic wait_txn(input int n, input string nm);
    int k;
    k = 0;
    while (txq.size() < n && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    if (txq.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s timeout got=%0d exp=%0d", nm, txq.size(), n);
    end
  endtask

  task automatic drop_all();
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

  logic [LW-1:0] a5;
  int exp_kind[6] = '{1, 0, 1, 0, 1, 0};

  initial begin
    a5 = {16{8'hA5}};

    // Reset held
    @(negedge clk);
    chk("rst_rd", 64'(pmem_read), 64'd0);
    chk("rst_i_cnt", 64'(i_grant_cnt), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Lone I read at 0x0040, three-cycle memory
    mem_auto = 1'b1; mem_cnt = 0; mem_lat = 3; mem_data = a5;
    txq.delete();
    i_pmem_read = 1'b1; i_pmem_address = 16'h0040;
    @(negedge clk);
    chk("t1_no_strobe_yet", 64'(pmem_read), 64'd0);
    @(negedge clk);
    chk("t1_strobe", 64'(pmem_read), 64'd1);
    chk("t1_addr", 64'(pmem_address), 64'h0040);
    wait_txn(1, "t1_wait");
    i_pmem_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_pulses", 64'(txq.size()), 64'd1);
    chk("t1_kind", 64'(txq[0].kind), 64'd0);
    chkw("t1_rdata", txq[0].rdata, a5);
    chk("t1_i_cnt", 64'(i_grant_cnt), 64'd1);

    // Reset in the middle of an I transaction, late response afterwards
    mem_auto = 1'b0;
    txq.delete();
    @(posedge clk); #2;
    i_pmem_read = 1'b1; i_pmem_address = 16'h0300;
    @(posedge clk); #2;
    @(negedge clk);
    chk("t4_serving", 64'(pmem_read), 64'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    chk("t4_rst_rd", 64'(pmem_read), 64'd0);
    chk("t4_rst_i_cnt", 64'(i_grant_cnt), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    i_pmem_read = 1'b0;
    pmem_resp = 1'b1; pmem_rdata = {8{16'hBEEF}};
    @(posedge clk); #2;
    pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_no_resp", 64'(txq.size()), 64'd0);
    chk("t4_i_cnt", 64'(i_grant_cnt), 64'd0);
    chk("t4_idle", 64'(pmem_read | pmem_write), 64'd0);

    // Simultaneous I read and D write straight after reset: D first
    mem_auto = 1'b1; mem_cnt = 0; mem_lat = 2; mem_data = {8{16'h1234}};
    txq.delete();
    @(posedge clk); #2;
    i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
    d_pmem_write = 1'b1; d_pmem_address = 16'h0200; d_pmem_wdata = {4{32'hDEADBEEF}};
    @(negedge clk);
    @(negedge clk);
    chk("t2_first_wr", 64'(pmem_write), 64'd1);
    chk("t2_first_addr", 64'(pmem_address), 64'h0200);
    wait_txn(2, "t2_wait");
    drop_all();
    chk("t2_kind0", 64'(txq[0].kind), 64'd1);
    chk("t2_wr0", 64'(txq[0].wr), 64'd1);
    chk("t2_kind1", 64'(txq[1].kind), 64'd0);
    chk("t2_addr1", 64'(txq[1].addr), 64'h0100);
    chk("t2_gap", 64'(txq[1].cyc - txq[0].cyc), 64'd3);
    repeat (2) @(negedge clk);
    chk("t2_i_cnt", 64'(i_grant_cnt), 64'd1);
    chk("t2_d_cnt", 64'(d_grant_cnt), 64'd1);

    // Both held for six transactions: strict alternation, one idle between
    txq.delete();
    @(posedge clk); #2;
    i_pmem_read = 1'b1; i_pmem_address = 16'h0110;
    d_pmem_write = 1'b1; d_pmem_address = 16'h0210; d_pmem_wdata = {4{32'h0BADF00D}};
    wait_txn(6, "t3_wait");
    drop_all();
    for (int k = 0; k < 6; k++) chk($sformatf("t3_kind%0d", k), 64'(txq[k].kind), 64'(exp_kind[k]));
    for (int k = 1; k < 6; k++) chk($sformatf("t3_gap%0d", k), 64'(txq[k].cyc - txq[k-1].cyc), 64'd3);

    // D read and write together: write wins
    txq.delete();
    @(posedge clk); #2;
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h0400;
    @(negedge clk);
    @(negedge clk);
    chk("t5_wr", 64'(pmem_write), 64'd1);
    chk("t5_rd", 64'(pmem_read), 64'd0);
    wait_txn(1, "t5_wait");
    drop_all();

    // D read only, single-cycle memory
    mem_lat = 1;
    txq.delete();
    @(posedge clk); #2;
    d_pmem_read = 1'b1; d_pmem_address = 16'h0500;
    @(negedge clk);
    @(negedge clk);
    chk("t6_rd", 64'(pmem_read), 64'd1);
    chk("t6_wr", 64'(pmem_write), 64'd0);
    wait_txn(1, "t6_wait");
    drop_all();

    repeat (3) @(negedge clk);
    chk("end_i_cnt", 64'(i_grant_cnt), 64'd4);
    chk("end_d_cnt", 64'(d_grant_cnt), 64'd6);
    chk("end_s_i_cnt", 64'(s_i_cnt), 64'd3);
    chk("end_s_d_cnt", 64'(s_d_cnt), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
